// File: rtl/cpu_types.sv
// Shared CPU front-end types: fetch queue entry layout and default sizing.
package cpu_types;
  localparam int          FQ_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fq_entry_t;
endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry array: one synchronous write port, one asynchronous read port.
module fq_storage
  import cpu_types::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fq_entry_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output fq_entry_t     rd_data
);
  // Contents carry no validity of their own, so the array is left unreset.
  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential reads, buffers returned words with
// their PCs for decode, and flushes/refetches on a taken redirect.
module fetch_queue
  import cpu_types::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = cpu_types::RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                mem_addr1,
  output logic                       mem_read1,
  input  logic [31:0]                mem_dout1,
  output logic                       de_valid,
  output logic [31:0]                de_ir,
  output logic [31:0]                de_pc,
  input  logic                       de_ready,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int          PW        = $clog2(DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          issue;
  logic          push;
  logic          pop;
  fq_entry_t     wr_entry;
  fq_entry_t     head_entry;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Credit counts the in-flight word but ignores a same-cycle pop, so a push
  // always finds a free slot.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = reset_n && !redirect && (occ < DEPTH_OCC);
  assign push  = inflight && !redirect;
  assign pop   = (count != '0) && de_ready && !redirect;

  assign mem_addr1 = fetch_pc;
  assign mem_read1 = issue;
  assign q_count   = count;
  assign de_valid  = (count != '0);
  assign de_ir     = de_valid ? head_entry.ir : '0;
  assign de_pc     = de_valid ? head_entry.pc : '0;

  assign wr_entry.ir = mem_dout1;
  assign wr_entry.pc = inflight_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (tail),
    .wr_data (wr_entry),
    .rd_addr (head),
    .rd_data (head_entry)
  );

  no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && count == DEPTH_CNT));
endmodule
